ts_packet_mux4: RTL

- Consumer side of the four per-tuner packet buffers. Each buffer advertises GOT_FULL_PACKET and delivers one 188-byte TS packet per GIVE_ME_ONE_PACKET request.
- Arbitrates round-robin among the four channels and requests one whole packet at a time.
- Forwards each packet as a single parallel TS stream on SYS_CLK, with valid, packet-sync and channel tag.
- Sits between the four buffers and the downstream TS output and packet-processing logic.

---
 rtl/ts_packet_mux4.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ts_packet_mux4.sv
// Round-robin consumer of four TS packet buffers: requests one whole packet at a
// time from a full buffer and forwards it as a single tagged 8-bit stream.
module ts_packet_mux4 #(
    parameter int         PKT_LEN    = 188,
    parameter int         RD_LATENCY = 2,
    parameter int         MIN_GAP    = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'h47
) (
    input  logic        SYS_CLK,
    input  logic        RST,
    input  logic [3:0]  GOT_FULL_PACKET,
    input  logic [31:0] DATA_IN,
    input  logic        EN,
    output logic [3:0]  GIVE_ME_ONE_PACKET,
    output logic [7:0]  TS_DATA,
    output logic        TS_VALID,
    output logic        TS_PSYNC,
    output logic [1:0]  TS_CHAN,
    output logic        SYNC_ERR,
    output logic        BUSY,
    output logic [2:0]  dbg_state
);

    // Buffer handshake: a one-cycle GIVE_ME_ONE_PACKET[i] pulse is the whole request;
    // the buffer answers RD_LATENCY cycles later with PKT_LEN contiguous bytes on its
    // DATA_IN lane and offers no back-pressure, so only one request may be in flight.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        STREAM = 3'd3,
        GAP    = 3'd4
    } state_t;

    localparam logic [7:0] LAST_IDX  = 8'(PKT_LEN - 1);
    localparam logic [7:0] WAIT_LOAD = 8'(RD_LATENCY - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(MIN_GAP);

    state_t      state;
    state_t      state_next;
    logic [1:0]  sel;
    logic [1:0]  last_served;
    logic [1:0]  pick;
    logic        pick_valid;
    logic [7:0]  byte_cnt;
    logic [7:0]  wait_cnt;
    logic [7:0]  gap_cnt;
    logic        last_byte;
    logic [7:0]  lane_byte;

    assign lane_byte = DATA_IN[{sel, 3'b000} +: 8];
    assign last_byte = (state == STREAM) && (byte_cnt == LAST_IDX);

    // Search starts just after the last served channel, wrapping modulo 4.
    always_comb begin
        logic [1:0] cand;
        pick       = 2'd0;
        pick_valid = 1'b0;
        cand       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_served + 2'(k);
            if (!pick_valid && GOT_FULL_PACKET[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (EN && pick_valid) state_next = REQ;
            REQ:     state_next = (RD_LATENCY <= 1) ? STREAM : WAIT;
            WAIT:    if (wait_cnt <= 8'd1) state_next = STREAM;
            STREAM:  if (last_byte) state_next = (MIN_GAP == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt <= 8'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign GIVE_ME_ONE_PACKET = (state == REQ) ? (4'b0001 << sel) : 4'b0000;
    assign BUSY               = (state != IDLE);
    assign dbg_state          = state;

    // Output stage lags DATA_IN by one cycle; TS_DATA and TS_CHAN hold between packets.
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            sel         <= 2'd0;
            last_served <= 2'd3;
            byte_cnt    <= 8'd0;
            wait_cnt    <= 8'd0;
            gap_cnt     <= 8'd0;
            TS_DATA     <= 8'd0;
            TS_VALID    <= 1'b0;
            TS_PSYNC    <= 1'b0;
            TS_CHAN     <= 2'd0;
            SYNC_ERR    <= 1'b0;
        end else begin
            TS_VALID <= 1'b0;
            TS_PSYNC <= 1'b0;
            SYNC_ERR <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (EN && pick_valid) sel <= pick;
                end
                REQ: begin
                    last_served <= sel;
                    wait_cnt    <= WAIT_LOAD;
                    byte_cnt    <= 8'd0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 8'd1;
                end
                STREAM: begin
                    TS_DATA  <= lane_byte;
                    TS_VALID <= 1'b1;
                    byte_cnt <= byte_cnt + 8'd1;
                    if (byte_cnt == 8'd0) begin
                        TS_PSYNC <= 1'b1;
                        TS_CHAN  <= sel;
                        SYNC_ERR <= (lane_byte != SYNC_BYTE);
                    end
                    if (last_byte) gap_cnt <= GAP_LOAD;
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                end
                default: begin
                    byte_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule
